// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI configuration register bank.
package spi_reg_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  localparam int unsigned FRAME_BITS = 16;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    OVERRUN
  } state_e;

endpackage

// File: rtl/spi_reg_bank_if.sv
// Raw SPI pin bundle: the master drives, the register bank receives.
interface spi_reg_bank_if;

   logic sclk;
   logic copi;
   logic ncs;

   modport master (output sclk, output copi, output ncs);
   modport slave  (input sclk, input copi, input ncs);

endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchroniser plus history flop producing level, rise and fall.
module sync_edge #(
   parameter int unsigned STAGES    = 2,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              hist_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {STAGES{RESET_VAL}};
         hist_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         hist_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~hist_q;
   assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_reg_bank.sv
// Write-only SPI mode-0 target holding the PWM peripheral configuration registers.
module spi_reg_bank
   import spi_reg_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned NUM_REGS    = 5
) (
   input  logic               clk,
   input  logic               rst,
   spi_reg_bank_if.slave      spi,
   output logic [7:0]         en_reg_out_7_0,
   output logic [7:0]         en_reg_out_15_8,
   output logic [7:0]         en_reg_pwm_7_0,
   output logic [7:0]         en_reg_pwm_15_8,
   output logic [7:0]         pwm_duty_cycle,
   output logic               wr_strobe,
   output logic               frame_err
);

   localparam int unsigned NUM_OUT   = 5;
   localparam logic [4:0]  FULL_CNT  = 5'(FRAME_BITS);

   logic sclk_level, sclk_rise, sclk_fall;
   logic copi_level, copi_rise, copi_fall;
   logic ncs_level, ncs_rise, ncs_fall;

   sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk   (clk),
      .rst   (rst),
      .din   (spi.sclk),
      .level (sclk_level),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
      .clk   (clk),
      .rst   (rst),
      .din   (spi.copi),
      .level (copi_level),
      .rise  (copi_rise),
      .fall  (copi_fall)
   );

   // Chip select idles high so a low pin at reset release still yields a fall.
   sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
      .clk   (clk),
      .rst   (rst),
      .din   (spi.ncs),
      .level (ncs_level),
      .rise  (ncs_rise),
      .fall  (ncs_fall)
   );

   logic unused_sync;
   assign unused_sync = ^{sclk_level, sclk_fall, copi_rise, copi_fall, ncs_level};

   state_e           state_q;
   logic [4:0]       bit_cnt_q;
   logic [15:0]      shift_q;
   logic [7:0]       regs_q [NUM_REGS];

   logic [6:0]       frame_addr;
   logic [7:0]       frame_data;
   logic             addr_ok;
   logic             frame_ok;

   assign frame_addr = shift_q[14:8];
   assign frame_data = shift_q[7:0];
   assign addr_ok    = {25'd0, frame_addr} < NUM_REGS;
   assign frame_ok   = (bit_cnt_q == FULL_CNT) && shift_q[15] && addr_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         wr_strobe <= 1'b0;
         frame_err <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
      end else begin
         wr_strobe <= 1'b0;
         frame_err <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (ncs_fall) begin
                  state_q   <= SHIFT;
                  bit_cnt_q <= '0;
               end
            end
            SHIFT: begin
               // ncs rise takes priority over a coincident sclk rise.
               if (ncs_rise) begin
                  state_q <= IDLE;
                  if (frame_ok) begin
                     wr_strobe <= 1'b1;
                     for (int i = 0; i < NUM_REGS; i++) begin
                        if (frame_addr == 7'(i)) regs_q[i] <= frame_data;
                     end
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else if (sclk_rise) begin
                  if (bit_cnt_q == FULL_CNT) begin
                     state_q <= OVERRUN;
                  end else begin
                     shift_q   <= {shift_q[14:0], copi_level};
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                  end
               end
            end
            OVERRUN: begin
               if (ncs_rise) begin
                  state_q   <= IDLE;
                  frame_err <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   logic [7:0] out_val [NUM_OUT];

   for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
      if (g < NUM_REGS) begin : g_impl
         assign out_val[g] = regs_q[g];
      end else begin : g_absent
         assign out_val[g] = 8'h00;
      end
   end

   assign en_reg_out_7_0  = out_val[ADDR_EN_OUT_LO];
   assign en_reg_out_15_8 = out_val[ADDR_EN_OUT_HI];
   assign en_reg_pwm_7_0  = out_val[ADDR_EN_PWM_LO];
   assign en_reg_pwm_15_8 = out_val[ADDR_EN_PWM_HI];
   assign pwm_duty_cycle  = out_val[ADDR_DUTY];

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench: each frame pushes its expected outcome, the monitor pops on strobe/error.
module tb_spi_reg_bank;

   logic clk = 1'b0;
   logic rst;
   logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
   logic [7:0] pwm_duty_cycle;
   logic wr_strobe, frame_err;

   spi_reg_bank_if spi ();

   spi_reg_bank #(.SYNC_STAGES(2), .NUM_REGS(5)) dut (
      .clk             (clk),
      .rst             (rst),
      .spi             (spi.slave),
      .en_reg_out_7_0  (en_reg_out_7_0),
      .en_reg_out_15_8 (en_reg_out_15_8),
      .en_reg_pwm_7_0  (en_reg_pwm_7_0),
      .en_reg_pwm_15_8 (en_reg_pwm_15_8),
      .pwm_duty_cycle  (pwm_duty_cycle),
      .wr_strobe       (wr_strobe),
      .frame_err       (frame_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        commit;
      logic [39:0] regs;
   } exp_t;

   exp_t       exp_q [$];
   logic [7:0] model [5];
   int         n_checks = 0;
   int         n_pass   = 0;
   int         n_strobe = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [39:0] pack_model();
      return {model[0], model[1], model[2], model[3], model[4]};
   endfunction

   function automatic logic [39:0] dut_regs();
      return {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};
   endfunction

   // Monitor: every strobe or error must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (wr_strobe || frame_err) begin
            if (wr_strobe) n_strobe++;
            if (exp_q.size() == 0) begin
               chk("unexpected_event", {62'd0, wr_strobe, frame_err}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("wr_strobe", {63'd0, wr_strobe}, {63'd0, e.commit});
               chk("frame_err", {63'd0, frame_err}, {63'd0, !e.commit});
               chk("regs_after_frame", {24'd0, dut_regs()}, {24'd0, e.regs});
            end
         end
      end
   end

   task automatic frame_start();
      @(negedge clk);
      spi.ncs = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic shift_bits(input logic [31:0] value, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         @(negedge clk);
         spi.copi = value[i];
         repeat (4) @(negedge clk);
         spi.sclk = 1'b1;
         repeat (4) @(negedge clk);
         spi.sclk = 1'b0;
      end
   endtask

   // Independent model of the commit rule, then raise ncs.
   task automatic frame_end_push(input logic [31:0] value, input int n);
      exp_t e;
      repeat (4) @(negedge clk);
      e.commit = (n == 16) && value[15] && (value[14:8] < 7'd5);
      if (e.commit) model[value[10:8]] = value[7:0];
      e.regs = pack_model();
      exp_q.push_back(e);
      spi.ncs = 1'b1;
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 40; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      chk(tag, 64'(exp_q.size()), 64'd0);
      repeat (4) @(negedge clk);
   endtask

   task automatic send_frame(input logic [31:0] value, input int n, input string tag);
      frame_start();
      shift_bits(value, n);
      frame_end_push(value, n);
      wait_drain(tag);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) model[i] = 8'h00;
      #1;
      chk("reset_regs", {24'd0, dut_regs()}, 64'd0);
      chk("reset_flags", {62'd0, wr_strobe, frame_err}, 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int strobes_before;

   initial begin
      rst = 1'b1;
      spi.sclk = 1'b0;
      spi.copi = 1'b0;
      spi.ncs  = 1'b1;
      for (int i = 0; i < 5; i++) model[i] = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_regs_init", {24'd0, dut_regs()}, 64'd0);
      chk("reset_flags_init", {62'd0, wr_strobe, frame_err}, 64'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Duty write with exact latency check after ncs rises.
      frame_start();
      shift_bits(32'h8455, 16);
      frame_end_push(32'h8455, 16);
      @(posedge clk); #1 chk("lat_edge1", {56'd0, pwm_duty_cycle}, 64'h00);
      @(posedge clk); #1 chk("lat_edge2", {56'd0, pwm_duty_cycle}, 64'h00);
      @(posedge clk); #1 chk("lat_edge3", {56'd0, pwm_duty_cycle}, 64'h55);
      wait_drain("drain_duty");

      strobes_before = n_strobe;
      send_frame(32'h80F0, 16, "drain_w0");
      send_frame(32'h810F, 16, "drain_w1");
      send_frame(32'h82AA, 16, "drain_w2");
      send_frame(32'h8355, 16, "drain_w3");
      chk("four_strobes", 64'(n_strobe - strobes_before), 64'd4);
      chk("enables", {32'd0, en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8},
          64'hF00FAA55);

      send_frame(32'h4227, 15, "drain_15bit");
      send_frame(32'h10299, 17, "drain_17bit");
      send_frame(32'h0455, 16, "drain_read");
      send_frame(32'h8A33, 16, "drain_oor");
      send_frame(32'h8011, 16, "drain_overwrite_a");
      send_frame(32'h8022, 16, "drain_overwrite_b");
      chk("overwrite", {56'd0, en_reg_out_7_0}, 64'h22);

      apply_reset();

      // Reset after ten bits of a frame: nothing may commit.
      frame_start();
      shift_bits(32'h8277 >> 6, 10);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) model[i] = 8'h00;
      spi.ncs = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("midframe_regs", {24'd0, dut_regs()}, 64'd0);
      send_frame(32'h8277, 16, "drain_after_abort");
      chk("pwm_lo_77", {56'd0, en_reg_pwm_7_0}, 64'h77);

      // Reset released with ncs low and sclk already high: first rise is lost.
      @(negedge clk);
      rst = 1'b1;
      spi.ncs  = 1'b0;
      spi.sclk = 1'b1;
      spi.copi = 1'b1;
      for (int i = 0; i < 5; i++) model[i] = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      spi.sclk = 1'b0;
      shift_bits(32'h0133, 15);
      frame_end_push(32'h0133, 15);
      wait_drain("drain_low_release");
      chk("low_release_regs", {24'd0, dut_regs()}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
